// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared constants for the 7-segment scan reader: the active-low glyph
//   table (Seg[6:0] = a..g, 0 = segment lit), the blank pattern, the idle
//   anode word and the number of multiplexed digits.
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG7_BLANK   = 7'h7F;
    localparam logic [3:0] SEG7_AN_IDLE = 4'hF;

    localparam logic [6:0] SEG7_GLYPH_0 = 7'h40;
    localparam logic [6:0] SEG7_GLYPH_1 = 7'h79;
    localparam logic [6:0] SEG7_GLYPH_2 = 7'h24;
    localparam logic [6:0] SEG7_GLYPH_3 = 7'h30;
    localparam logic [6:0] SEG7_GLYPH_4 = 7'h19;
    localparam logic [6:0] SEG7_GLYPH_5 = 7'h12;
    localparam logic [6:0] SEG7_GLYPH_6 = 7'h02;
    localparam logic [6:0] SEG7_GLYPH_7 = 7'h78;
    localparam logic [6:0] SEG7_GLYPH_8 = 7'h00;
    localparam logic [6:0] SEG7_GLYPH_9 = 7'h10;
    localparam logic [6:0] SEG7_GLYPH_A = 7'h08;
    localparam logic [6:0] SEG7_GLYPH_B = 7'h03;
    localparam logic [6:0] SEG7_GLYPH_C = 7'h46;
    localparam logic [6:0] SEG7_GLYPH_D = 7'h21;
    localparam logic [6:0] SEG7_GLYPH_E = 7'h06;
    localparam logic [6:0] SEG7_GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg7_glyph_to_nibble.sv
// ---------------------------------------------------------------------------
// seg7_glyph_to_nibble
//   Combinational inverse of the nibble->segment decoder.
//   Ports:
//     seg_i    [6:0]  active-low segments a..g
//     valid_o         1 when seg_i is exactly one of the 16 hex glyphs
//     nibble_o [3:0]  decoded hex value (0 when not valid)
// ---------------------------------------------------------------------------
module seg7_glyph_to_nibble
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        valid_o  = 1'b1;
        nibble_o = 4'h0;
        case (seg_i)
            SEG7_GLYPH_0: nibble_o = 4'h0;
            SEG7_GLYPH_1: nibble_o = 4'h1;
            SEG7_GLYPH_2: nibble_o = 4'h2;
            SEG7_GLYPH_3: nibble_o = 4'h3;
            SEG7_GLYPH_4: nibble_o = 4'h4;
            SEG7_GLYPH_5: nibble_o = 4'h5;
            SEG7_GLYPH_6: nibble_o = 4'h6;
            SEG7_GLYPH_7: nibble_o = 4'h7;
            SEG7_GLYPH_8: nibble_o = 4'h8;
            SEG7_GLYPH_9: nibble_o = 4'h9;
            SEG7_GLYPH_A: nibble_o = 4'hA;
            SEG7_GLYPH_B: nibble_o = 4'hB;
            SEG7_GLYPH_C: nibble_o = 4'hC;
            SEG7_GLYPH_D: nibble_o = 4'hD;
            SEG7_GLYPH_E: nibble_o = 4'hE;
            SEG7_GLYPH_F: nibble_o = 4'hF;
            default:      valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// seg7_scan_reader
//   Watches a multiplexed 4-digit active-low 7-segment scan bus and rebuilds
//   the displayed 16-bit hex value. A bus word must stay unchanged for
//   STABLE_CYCLES clocks (after a 2-flop synchronizer) before it is committed,
//   which filters scan transitions and glitches.
//   Optional feature macro: SEG7_DP_CAPTURE_EN (decimal point capture, dp_o).
//   Ports:
//     clk_i                 rising-edge clock
//     rst_i                 asynchronous active-high reset
//     an_i          [3:0]   anodes, active-low, an_i[0] = rightmost digit
//     seg_i         [7:0]   segments, active-low, [6:0]=a..g, [7]=dp
//     value_o       [15:0]  reconstructed value, nibble i = digit i
//     digit_valid_o [3:0]   digit i holds a decoded hex glyph
//     update_o              1-cycle pulse on a nibble / valid-bit commit
//     err_o                 1-cycle pulse on illegal glyph or multi-anode
//     dp_o          [3:0]   captured decimal points (SEG7_DP_CAPTURE_EN only)
// ---------------------------------------------------------------------------
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
)
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_DIGITS-1:0]   an_i,
    input  logic [7:0]              seg_i,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic [NUM_DIGITS-1:0]   digit_valid_o,
    output logic                    update_o,
    output logic                    err_o
`ifdef SEG7_DP_CAPTURE_EN
    ,
    output logic [NUM_DIGITS-1:0]   dp_o
`endif
);

    // Without dp capture, Seg[7] is masked so dp flicker never restarts settling.
`ifdef SEG7_DP_CAPTURE_EN
    localparam logic [11:0] CMP_MASK = 12'hFFF;
`else
    localparam logic [11:0] CMP_MASK = 12'hF7F;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);

    logic [11:0]             sync1_q, sync2_q;
    logic [11:0]             prev_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [15:0]             value_q, value_d;
    logic [NUM_DIGITS-1:0]   dv_q, dv_d;
    logic                    upd_q, upd_d;
    logic                    err_q, err_d;

    logic [11:0]             word_w;
    logic                    stable_w;
    logic                    commit_w;
    logic [3:0]              an_s_w;
    logic [6:0]              seg_s_w;
    logic                    an_single_w;
    logic                    an_multi_w;
    logic [1:0]              idx_w;
    logic                    glyph_valid_w;
    logic [3:0]              glyph_nib_w;

    assign word_w   = sync2_q & CMP_MASK;
    assign an_s_w   = sync2_q[11:8];
    assign seg_s_w  = sync2_q[6:0];
    assign stable_w = (word_w == prev_q);
    // Exactly one edge: the counter steps from STABLE_CYCLES-1 to STABLE_CYCLES.
    assign commit_w = stable_w && (cnt_q == CNT_PRE);

    always_comb begin
        if (!stable_w)
            cnt_d = '0;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
    end

    // Anode classification: idle, exactly one digit low, or several low.
    always_comb begin
        an_single_w = 1'b1;
        an_multi_w  = 1'b0;
        idx_w       = 2'd0;
        case (an_s_w)
            4'hE:         idx_w = 2'd0;
            4'hD:         idx_w = 2'd1;
            4'hB:         idx_w = 2'd2;
            4'h7:         idx_w = 2'd3;
            SEG7_AN_IDLE: an_single_w = 1'b0;
            default: begin
                an_single_w = 1'b0;
                an_multi_w  = 1'b1;
            end
        endcase
    end

    seg7_glyph_to_nibble u_glyph (
        .seg_i    (seg_s_w),
        .valid_o  (glyph_valid_w),
        .nibble_o (glyph_nib_w)
    );

`ifdef SEG7_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
`endif

    always_comb begin
        value_d = value_q;
        dv_d    = dv_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
        dp_d    = dp_q;
`endif
        if (commit_w) begin
            if (an_multi_w) begin
                err_d = 1'b1;
            end else if (an_single_w) begin
                if (seg_s_w == SEG7_BLANK) begin
                    dv_d[idx_w] = 1'b0;
                    upd_d       = 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
                    dp_d[idx_w] = ~sync2_q[7];
`endif
                end else if (glyph_valid_w) begin
                    value_d[{idx_w, 2'b00} +: 4] = glyph_nib_w;
                    dv_d[idx_w] = 1'b1;
                    upd_d       = 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
                    dp_d[idx_w] = ~sync2_q[7];
`endif
                end else begin
                    dv_d[idx_w] = 1'b0;
                    err_d       = 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
                    dp_d[idx_w] = 1'b0;
`endif
                end
            end
        end
    end

    // Synchronizer resets to the idle bus (all ones) so release looks quiet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= CMP_MASK;
            cnt_q   <= '0;
            value_q <= '0;
            dv_q    <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {an_i, seg_i};
            sync2_q <= sync1_q;
            prev_q  <= word_w;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            dv_q    <= dv_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

`ifdef SEG7_DP_CAPTURE_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            dp_q <= '0;
        else
            dp_q <= dp_d;
    end
    assign dp_o = dp_q;
`endif

    assign value_o       = value_q;
    assign digit_valid_o = dv_q;
    assign update_o      = upd_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_reader
//   Directed scenarios plus randomized scan traffic for seg7_scan_reader.
//   The reference model keeps the history of sampled bus words and decides a
//   commit from "same word on STABLE_CYCLES+1 consecutive samples, different
//   before", two clocks earlier (synchronizer delay).
// ---------------------------------------------------------------------------
module tb_seg7_scan_reader;

    localparam int S = 8;
`ifdef SEG7_DP_CAPTURE_EN
    localparam logic [11:0] MASK = 12'hFFF;
`else
    localparam logic [11:0] MASK = 12'hF7F;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] value;
    logic [3:0]  dv;
    logic        upd;
    logic        err;
`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0]  dp;
`endif

    int total = 0;
    int bad   = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [11:0] hq[$];
    logic [15:0] exp_value;
    logic [3:0]  exp_dv;
    logic [3:0]  exp_dp;
    logic        exp_upd;
    logic        exp_err;

    always #5 clk = ~clk;

    seg7_scan_reader #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .an_i          (an),
        .seg_i         (seg),
        .value_o       (value),
        .digit_valid_o (dv),
        .update_o      (upd),
        .err_o         (err)
`ifdef SEG7_DP_CAPTURE_EN
        ,
        .dp_o          (dp)
`endif
    );

    task automatic model_commit(input logic [11:0] w);
        logic [3:0] a;
        logic [6:0] g;
        int zeros, idx, nib;
        a = w[11:8];
        g = w[6:0];
        zeros = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; idx = i; end
        if (zeros >= 2) begin
            exp_err = 1'b1;
        end else if (zeros == 1) begin
            nib = -1;
            for (int i = 0; i < 16; i++) if (glyph[i] == g) nib = i;
            if (g == 7'h7F) begin
                exp_dv[idx] = 1'b0;
                exp_upd = 1'b1;
                exp_dp[idx] = ~w[7];
            end else if (nib >= 0) begin
                exp_value[4*idx +: 4] = nib[3:0];
                exp_dv[idx] = 1'b1;
                exp_upd = 1'b1;
                exp_dp[idx] = ~w[7];
            end else begin
                exp_dv[idx] = 1'b0;
                exp_err = 1'b1;
                exp_dp[idx] = 1'b0;
            end
        end
    endtask

    // Advance one clock, update the model at the edge, return at the falling edge.
    task automatic tick();
        int n, k;
        bit commit;
        @(posedge clk);
        exp_upd = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            hq.delete();
            for (int i = 0; i < S + 3; i++) hq.push_back(12'hFFF & MASK);
            exp_value = '0;
            exp_dv = '0;
            exp_dp = '0;
        end else begin
            hq.push_back({an, seg} & MASK);
            n = hq.size();
            k = n - 3 - S;
            commit = (hq[k-1] != hq[k]);
            for (int j = k + 1; j <= k + S; j++) if (hq[j] != hq[k]) commit = 1'b0;
            if (commit) model_commit(hq[k]);
            if (hq.size() > 64) void'(hq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic test_power_on();
        rst = 1'b1; an = 4'hF; seg = 8'hFF;
        repeat (3) tick();
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL reset_value: got %h want 0000", value); end
        total++; if (dv !== 4'h0) begin bad++; $display("FAIL reset_dv: got %h want 0", dv); end
        total++; if (upd !== 1'b0) begin bad++; $display("FAIL reset_upd: got %b want 0", upd); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
`ifdef SEG7_DP_CAPTURE_EN
        total++; if (dp !== 4'h0) begin bad++; $display("FAIL reset_dp: got %h want 0", dp); end
`endif
        rst = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_scan_1234();
        logic [3:0] ans [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] sgs [4] = '{8'h19, 8'h30, 8'h24, 8'h79};
        int ups, first;
        ups = 0;
        first = -1;
        for (int d = 0; d < 4; d++) begin
            an = ans[d]; seg = sgs[d];
            for (int t = 1; t <= 20; t++) begin
                tick();
                if (upd === 1'b1) begin
                    ups++;
                    if (d == 0 && first < 0) first = t;
                end
            end
        end
        total++; if (first != S + 3) begin bad++; $display("FAIL scan_latency: got %0d want %0d", first, S + 3); end
        total++; if (ups != 4) begin bad++; $display("FAIL scan_updates: got %0d want 4", ups); end
        total++; if (value !== 16'h1234) begin bad++; $display("FAIL scan_value: got %h want 1234", value); end
        total++; if (dv !== 4'hF) begin bad++; $display("FAIL scan_dv: got %h want F", dv); end
    endtask

    task automatic test_glitch();
        int ups;
        ups = 0;
        an = 4'hF; seg = 8'hFF;
        repeat (20) tick();
        an = 4'hE; seg = 8'h80;
        repeat (5) begin tick(); if (upd === 1'b1) ups++; end
        an = 4'hF; seg = 8'hFF;
        repeat (20) begin tick(); if (upd === 1'b1) ups++; end
        total++; if (ups != 0) begin bad++; $display("FAIL glitch_updates: got %0d want 0", ups); end
        total++; if (value !== 16'h1234) begin bad++; $display("FAIL glitch_value: got %h want 1234", value); end
    endtask

    task automatic test_illegal();
        int errs, ups;
        errs = 0; ups = 0;
        an = 4'hE; seg = 8'hFE;
        repeat (20) begin
            tick();
            if (err === 1'b1) errs++;
            if (upd === 1'b1) ups++;
        end
        total++; if (errs != 1) begin bad++; $display("FAIL illegal_err: got %0d want 1", errs); end
        total++; if (ups != 0) begin bad++; $display("FAIL illegal_upd: got %0d want 0", ups); end
        total++; if (dv !== 4'hE) begin bad++; $display("FAIL illegal_dv: got %h want E", dv); end
        total++; if (value[3:0] !== 4'h4) begin bad++; $display("FAIL illegal_nibble: got %h want 4", value[3:0]); end
    endtask

    task automatic test_multi_anode();
        int errs, ups;
        errs = 0; ups = 0;
        an = 4'hC; seg = 8'h79;
        repeat (20) begin
            tick();
            if (err === 1'b1) errs++;
            if (upd === 1'b1) ups++;
        end
        total++; if (errs != 1) begin bad++; $display("FAIL multi_err: got %0d want 1", errs); end
        total++; if (ups != 0) begin bad++; $display("FAIL multi_upd: got %0d want 0", ups); end
        total++; if (value !== 16'h1234) begin bad++; $display("FAIL multi_value: got %h want 1234", value); end
        total++; if (dv !== 4'hE) begin bad++; $display("FAIL multi_dv: got %h want E", dv); end
        errs = 0; ups = 0;
        an = 4'hF; seg = 8'hFF;
        repeat (20) begin
            tick();
            if (err === 1'b1) errs++;
            if (upd === 1'b1) ups++;
        end
        total++; if (errs + ups != 0) begin bad++; $display("FAIL idle_pulses: got %0d want 0", errs + ups); end
    endtask

`ifdef SEG7_DP_CAPTURE_EN
    task automatic test_dp();
        int ups;
        an = 4'hB; seg = 8'h79;
        repeat (20) tick();
        total++; if (dp[2] !== 1'b1) begin bad++; $display("FAIL dp_on: got %b want 1", dp[2]); end
        total++; if (value[11:8] !== 4'h1) begin bad++; $display("FAIL dp_value: got %h want 1", value[11:8]); end
        total++; if (dp !== exp_dp) begin bad++; $display("FAIL dp_word: got %h want %h", dp, exp_dp); end
        ups = 0;
        seg = 8'hF9;
        repeat (20) begin tick(); if (upd === 1'b1) ups++; end
        total++; if (ups != 1) begin bad++; $display("FAIL dp_toggle_upd: got %0d want 1", ups); end
        total++; if (dp[2] !== 1'b0) begin bad++; $display("FAIL dp_off: got %b want 0", dp[2]); end
        total++; if (value[11:8] !== 4'h1) begin bad++; $display("FAIL dp_toggle_value: got %h want 1", value[11:8]); end
    endtask
`endif

    task automatic test_random();
        int cat, hold, shown;
        shown = 0;
        for (int r = 0; r < 80; r++) begin
            cat = $urandom_range(0, 9);
            seg = {1'($urandom_range(0, 1)), 7'h7F};
            case (cat)
                0: begin an = 4'hF; seg = 8'hFF; end
                1: begin
                    an = 4'($urandom_range(0, 15));
                    while ($countones(~an) < 2) an = 4'($urandom_range(0, 15));
                end
                2: an = ~(4'b0001 << $urandom_range(0, 3));
                3: begin
                    an = ~(4'b0001 << $urandom_range(0, 3));
                    seg[6:0] = 7'($urandom_range(0, 127));
                end
                default: begin
                    an = ~(4'b0001 << $urandom_range(0, 3));
                    seg[6:0] = glyph[$urandom_range(0, 15)];
                end
            endcase
            hold = $urandom_range(1, 20);
            repeat (hold) begin
                tick();
                total++;
                if (value !== exp_value || dv !== exp_dv || upd !== exp_upd || err !== exp_err) begin
                    bad++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL rand_outputs: got v=%h dv=%h u=%b e=%b want v=%h dv=%h u=%b e=%b",
                                 value, dv, upd, err, exp_value, exp_dv, exp_upd, exp_err);
                    end
                end
                total++;
                if ((upd & err) !== 1'b0) begin bad++; $display("FAIL rand_exclusive: got upd=%b err=%b want not both", upd, err); end
`ifdef SEG7_DP_CAPTURE_EN
                total++;
                if (dp !== exp_dp) begin bad++; $display("FAIL rand_dp: got %h want %h", dp, exp_dp); end
`endif
            end
        end
    endtask

    task automatic test_reset();
        int ups;
        an = 4'h7; seg = 8'h12;
        repeat (20) tick();
        an = 4'hE; seg = 8'h40;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL async_value: got %h want 0000", value); end
        total++; if (dv !== 4'h0) begin bad++; $display("FAIL async_dv: got %h want 0", dv); end
        total++; if (upd !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL async_pulses: got u=%b e=%b want 0", upd, err); end
        an = 4'hF; seg = 8'hFF;
        repeat (2) tick();
        rst = 1'b0;
        ups = 0;
        repeat (20) begin tick(); if (upd === 1'b1 || err === 1'b1) ups++; end
        total++; if (ups != 0) begin bad++; $display("FAIL reset_abort: got %0d pulses want 0", ups); end
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL reset_abort_value: got %h want 0000", value); end
    endtask

    initial begin
        test_power_on();
        test_scan_1234();
        test_glitch();
        test_illegal();
        test_multi_anode();
`ifdef SEG7_DP_CAPTURE_EN
        test_dp();
`endif
        test_random();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
